bgr_startup_ctrl: RTL and testbench



---
 rtl/bgr_startup_ctrl.sv | 179 +++++++++++++++++
 tb/tb_bgr_startup_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bgr_startup_ctrl.sv
// rtl/bgr_startup_ctrl.sv - bandgap reference start-up, qualification and retry sequencer
module bgr_startup_ctrl #(
  parameter int KICK_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 1024,
  parameter int CHECK_CYCLES  = 8,
  parameter int CHECK_TIMEOUT = 64,
  parameter int RETRY_MAX     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_req,
  input  logic [3:0] trim_in,
  input  logic       cmp_ok,
  output logic       bgr_en,
  output logic       startup_kick,
  output logic [3:0] trim_code,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state,
  output logic [2:0] retry_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KICK   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_READY  = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  // One shared phase timer covers KICK, SETTLE and the CHECK timeout.
  localparam int TMAX_KS = (KICK_CYCLES > SETTLE_CYCLES) ? KICK_CYCLES : SETTLE_CYCLES;
  localparam int TMAX    = (TMAX_KS > CHECK_TIMEOUT) ? TMAX_KS : CHECK_TIMEOUT;
  localparam int TW      = $clog2(TMAX + 1);
  localparam int QW      = $clog2(CHECK_CYCLES + 1);

  localparam logic [TW-1:0] KICK_LAST   = TW'(KICK_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(CHECK_TIMEOUT - 1);
  localparam logic [QW-1:0] QUAL_LAST   = QW'(CHECK_CYCLES - 1);
  localparam logic [2:0]    RMAX        = 3'(RETRY_MAX);

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [QW-1:0] qual_q, qual_d;
  logic [2:0]    retry_q, retry_d;
  logic [3:0]    trim_q, trim_d;
  logic          cmp_meta_q, cmp_sync_q;
  logic          fail;

  logic          bgr_en_q, kick_q, ready_q, fault_q;
  logic [3:0]    trim_code_q;
  logic [2:0]    state_o_q, retry_o_q;

  // Two-flop synchronizer for the asynchronous comparator output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_meta_q <= 1'b0;
      cmp_sync_q <= 1'b0;
    end else begin
      cmp_meta_q <= cmp_ok;
      cmp_sync_q <= cmp_meta_q;
    end
  end

  // Sequencer state, timers, retry count and latched trim.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      qual_q  <= '0;
      retry_q <= 3'd0;
      trim_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      qual_q  <= qual_d;
      retry_q <= retry_d;
      trim_q  <= trim_d;
    end
  end

  // Next-state: phase timing, qualification/loss counting, retry and abort.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    qual_d  = qual_q;
    retry_d = retry_q;
    trim_d  = trim_q;
    fail    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en_req) begin
          state_d = ST_KICK;
          trim_d  = trim_in;
        end
      end
      ST_KICK: begin
        if (tmr_q == KICK_LAST) state_d = ST_SETTLE;
        else                    tmr_d   = tmr_q + TW'(1);
      end
      ST_SETTLE: begin
        if (tmr_q == SETTLE_LAST) state_d = ST_CHECK;
        else                      tmr_d   = tmr_q + TW'(1);
      end
      ST_CHECK: begin
        // A qualify on the last timeout cycle takes priority over the timeout.
        if (cmp_sync_q && (qual_q == QUAL_LAST)) begin
          state_d = ST_READY;
        end else begin
          qual_d = cmp_sync_q ? (qual_q + QW'(1)) : '0;
          if (tmr_q == TMO_LAST) fail  = 1'b1;
          else                   tmr_d = tmr_q + TW'(1);
        end
      end
      ST_READY: begin
        if (!cmp_sync_q && (qual_q == QUAL_LAST)) fail   = 1'b1;
        else                                      qual_d = !cmp_sync_q ? (qual_q + QW'(1)) : '0;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (fail) begin
      retry_d = (retry_q == RMAX) ? retry_q : (retry_q + 3'd1);
      state_d = (retry_d == RMAX) ? ST_FAULT : ST_KICK;
    end

    // Dropping the enable request aborts from anywhere.
    if (!en_req) state_d = ST_IDLE;

    if (state_d == ST_IDLE) begin
      retry_d = 3'd0;
      trim_d  = 4'd0;
    end

    if (state_d != state_q) begin
      tmr_d  = '0;
      qual_d = '0;
    end
  end

  // Registered output decode so no input reaches a pin combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bgr_en_q    <= 1'b0;
      kick_q      <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      trim_code_q <= 4'd0;
      state_o_q   <= 3'd0;
      retry_o_q   <= 3'd0;
    end else begin
      bgr_en_q    <= (state_q == ST_KICK) || (state_q == ST_SETTLE) ||
                     (state_q == ST_CHECK) || (state_q == ST_READY);
      kick_q      <= (state_q == ST_KICK);
      ready_q     <= (state_q == ST_READY);
      fault_q     <= (state_q == ST_FAULT);
      trim_code_q <= trim_q;
      state_o_q   <= state_q;
      retry_o_q   <= retry_q;
    end
  end

  assign bgr_en       = bgr_en_q;
  assign startup_kick = kick_q;
  assign ready        = ready_q;
  assign fault        = fault_q;
  assign trim_code    = trim_code_q;
  assign state        = state_o_q;
  assign retry_cnt    = retry_o_q;

endmodule

// File: tb/tb_bgr_startup_ctrl.sv
// tb/tb_bgr_startup_ctrl.sv - scoreboard bench for bgr_startup_ctrl
module tb_bgr_startup_ctrl;

  localparam int K   = 4;
  localparam int S   = 16;
  localparam int C   = 3;
  localparam int TMO = 8;
  localparam int RM  = 2;

  logic       clk;
  logic       rst_n;
  logic       en_req;
  logic [3:0] trim_in;
  logic       cmp_ok;
  logic       bgr_en;
  logic       startup_kick;
  logic [3:0] trim_code;
  logic       ready;
  logic       fault;
  logic [2:0] state;
  logic [2:0] retry_cnt;

  bgr_startup_ctrl #(
    .KICK_CYCLES  (K),
    .SETTLE_CYCLES(S),
    .CHECK_CYCLES (C),
    .CHECK_TIMEOUT(TMO),
    .RETRY_MAX    (RM)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_req      (en_req),
    .trim_in     (trim_in),
    .cmp_ok      (cmp_ok),
    .bgr_en      (bgr_en),
    .startup_kick(startup_kick),
    .trim_code   (trim_code),
    .ready       (ready),
    .fault       (fault),
    .state       (state),
    .retry_cnt   (retry_cnt)
  );

  typedef struct {
    int          cyc;
    logic [13:0] vec;
  } ev_t;

  ev_t         exp_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;
  bit          mon_en = 0;
  logic [13:0] prev = '0;
  logic [13:0] cur;
  ev_t         e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] mk(input logic b, input logic k, input logic [3:0] t,
                                     input logic r, input logic f, input logic [2:0] st,
                                     input logic [2:0] rc);
    return {b, k, t, r, f, st, rc};
  endfunction

  function automatic logic [13:0] outs();
    return {bgr_en, startup_kick, trim_code, ready, fault, state, retry_cnt};
  endfunction

  task automatic push(input int c, input logic [13:0] v);
    ev_t x;
    x.cyc = c;
    x.vec = v;
    exp_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  // Expected timeline of one start-up attempt whose KICK begins at edge a.
  task automatic attempt(input int a, input logic [3:0] t, input logic [2:0] r, input bit good);
    push(a + 1,         mk(1'b1, 1'b1, t, 1'b0, 1'b0, 3'd1, r));
    push(a + 1 + K,     mk(1'b1, 1'b0, t, 1'b0, 1'b0, 3'd2, r));
    push(a + 1 + K + S, mk(1'b1, 1'b0, t, 1'b0, 1'b0, 3'd3, r));
    if (good)
      push(a + 1 + K + S + C, mk(1'b1, 1'b0, t, 1'b1, 1'b0, 3'd4, r));
    else if (int'(r) + 1 == RM)
      push(a + 1 + K + S + TMO, mk(1'b0, 1'b0, t, 1'b0, 1'b1, 3'd5, r + 3'd1));
  endtask

  // Monitor: every change of the output vector must match the next expected event.
  always @(negedge clk) begin
    if (mon_en) begin
      cur = outs();
      if (cur !== prev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_change cyc=%0d got=%h required no change from %h", cyc, cur, prev);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.vec !== cur) begin
            n_err++;
            $display("FAIL event got cyc=%0d vec=%h required cyc=%0d vec=%h", cyc, cur, e.cyc, e.vec);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic check_zero(input string name);
    n_checks++;
    if (outs() !== 14'd0) begin
      n_err++;
      $display("FAIL %s got=%h required=0", name, outs());
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 300) begin
      tick();
      k++;
    end
    repeat (3) tick();
    n_checks++;
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain_%s pending=%0d required=0 next_cyc=%0d", name, exp_q.size(), exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  task automatic start(input logic cmp, output int a, output logic [3:0] t);
    cmp_ok = cmp;
    repeat ($urandom_range(3, 6)) tick();
    t       = 4'($urandom);
    trim_in = t;
    en_req  = 1'b1;
    a       = cyc + 1;
  endtask

  task automatic stop_en();
    en_req = 1'b0;
    push(cyc + 2, 14'd0);
    tick();
  endtask

  task automatic run_scn(input int kind);
    int         a, a2, d, x;
    logic [3:0] t;
    case (kind)
      0: begin
        start(1'b1, a, t);
        attempt(a, t, 3'd0, 1'b1);
        tick();
        trim_in = 4'($urandom);
        wait_until(a + K + S + C + 2 + int'($urandom_range(0, 5)));
        stop_en();
        drain("nominal");
      end
      1: begin
        start(1'b0, a, t);
        attempt(a, t, 3'd0, 1'b0);
        a2 = a + K + S + TMO;
        attempt(a2, t, 3'd1, 1'b1);
        tick();
        trim_in = 4'($urandom);
        wait_until(a2 + int'($urandom_range(0, K + S - 4)));
        cmp_ok = 1'b1;
        wait_until(a2 + K + S + C + 2);
        stop_en();
        drain("one_bad");
      end
      2: begin
        start(1'b0, a, t);
        attempt(a, t, 3'd0, 1'b0);
        a2 = a + K + S + TMO;
        attempt(a2, t, 3'd1, 1'b0);
        wait_until(a2 + K + S + TMO + 1 + int'($urandom_range(1, 5)));
        stop_en();
        drain("persistent");
      end
      3: begin
        start(1'b1, a, t);
        attempt(a, t, 3'd0, 1'b1);
        wait_until(a + K + S + C + 2);
        cmp_ok = 1'b0;
        repeat ($urandom_range(1, C - 1)) tick();
        cmp_ok = 1'b1;
        repeat (C + 4) tick();
        d = cyc + 1;
        cmp_ok = 1'b0;
        attempt(d + C + 1, t, 3'd1, 1'b1);
        trim_in = 4'($urandom);
        repeat ($urandom_range(C, C + 3)) tick();
        cmp_ok = 1'b1;
        wait_until(d + C + 1 + K + S + C + 2);
        stop_en();
        drain("dropout");
      end
      default: begin
        start(1'b1, a, t);
        push(a + 1,     mk(1'b1, 1'b1, t, 1'b0, 1'b0, 3'd1, 3'd0));
        push(a + 1 + K, mk(1'b1, 1'b0, t, 1'b0, 1'b0, 3'd2, 3'd0));
        x = int'($urandom_range(1, S));
        d = a + K + x;
        wait_until(d - 1);
        en_req = 1'b0;
        push(d + 1, 14'd0);
        wait_until(d + 2);
        drain("abort");
      end
    endcase
  endtask

  initial begin
    int         a;
    logic [3:0] t;
    rst_n   = 1'b0;
    en_req  = 1'b0;
    cmp_ok  = 1'b0;
    trim_in = 4'd0;
    #3;
    check_zero("reset_state");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    for (int rep = 0; rep < 2; rep++)
      for (int k = 0; k < 5; k++)
        run_scn(k);

    start(1'b1, a, t);
    attempt(a, t, 3'd0, 1'b1);
    wait_until(a + K + S + C + 3);
    drain("pre_reset");
    @(posedge clk);
    #3;
    push(cyc, 14'd0);
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    en_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    drain("async_reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
